// File: rtl/core_pkg.sv
// Shared load/store types for the data memory path: access width encoding,
// controller state encoding and the alignment / byte-enable rules.
package core_pkg;

   typedef enum logic [1:0] {
      MT_WORD = 2'b00,
      MT_BYTE = 2'b01,
      MT_HALF = 2'b10,
      MT_RSVD = 2'b11
   } mem_type_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_ISSUE = 2'b01,
      ST_WAIT  = 2'b10,
      ST_RESP  = 2'b11
   } mem_state_e;

   localparam logic MEMSIGN_SIGNED   = 1'b0;
   localparam logic MEMSIGN_UNSIGNED = 1'b1;

   // Misaligned halves/words and the reserved width never reach the RAM.
   function automatic logic access_error(input mem_type_e mem_type, input logic [1:0] offset);
      case (mem_type)
         MT_WORD: return (offset != 2'b00);
         MT_HALF: return offset[0];
         MT_BYTE: return 1'b0;
         default: return 1'b1;
      endcase
   endfunction

   function automatic logic [3:0] byte_enables(input mem_type_e mem_type, input logic [1:0] offset);
      case (mem_type)
         MT_BYTE: return 4'b0001 << offset;
         MT_HALF: return offset[1] ? 4'b1100 : 4'b0011;
         MT_WORD: return 4'b1111;
         default: return 4'b0000;
      endcase
   endfunction

endpackage

// File: rtl/load_extend.sv
// Picks the addressed byte/half out of a RAM word and sign- or zero-extends it.
// Purely combinational so it can sit behind any read source.
module load_extend
   import core_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  offset,
   input  mem_type_e   mem_type,
   input  logic        mem_sign,
   output logic [31:0] result
);

   logic [7:0]  lane_byte;
   logic [15:0] lane_half;
   logic        fill;

   always_comb begin
      lane_byte = word[{offset, 3'b000} +: 8];
      lane_half = word[{offset[1], 4'b0000} +: 16];
      fill      = 1'b0;
      result    = word;
      case (mem_type)
         MT_BYTE: begin
            fill   = (mem_sign == MEMSIGN_SIGNED) && lane_byte[7];
            result = {{24{fill}}, lane_byte};
         end
         MT_HALF: begin
            fill   = (mem_sign == MEMSIGN_SIGNED) && lane_half[15];
            result = {{16{fill}}, lane_half};
         end
         default: result = word;
      endcase
   end

endmodule

// File: rtl/datamem_ctrl.sv
// Load/store responder between the core and a word-wide synchronous RAM.
// Handshake: the core holds Req_i until it sees Ready_o=1 at a clock edge; that edge accepts the request. Done_o pulses once per accepted request.
module datamem_ctrl
   import core_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int READ_LAT   = 1
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  Req_i,
   input  logic [ADDR_WIDTH-1:0] Addr_i,
   input  logic [DATA_WIDTH-1:0] WriteData_i,
   input  logic                  MemWrite_i,
   input  logic [1:0]            MemType_i,
   input  logic                  MemSign_i,
   output logic                  Ready_o,
   output logic                  Done_o,
   output logic [DATA_WIDTH-1:0] ReadData_o,
   output logic                  Misalign_o,
   output logic                  MemReq_o,
   output logic                  MemWe_o,
   output logic [ADDR_WIDTH-3:0] MemAddr_o,
   output logic [3:0]            MemBe_o,
   output logic [DATA_WIDTH-1:0] MemWdata_o,
   input  logic [DATA_WIDTH-1:0] MemRdata_i,
   output mem_state_e            dbg_state
);

   localparam int CNT_W = (READ_LAT < 2) ? 1 : $clog2(READ_LAT + 1);
   localparam logic [CNT_W-1:0] LAT_CNT = CNT_W'(READ_LAT);

   mem_state_e            state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [DATA_WIDTH-1:0] rdata_q;
   logic [DATA_WIDTH-1:0] ext_data;
   logic [DATA_WIDTH-1:0] store_data;
   logic [CNT_W-1:0]      cnt_q;
   mem_type_e             type_q;
   logic                  we_q;
   logic                  sign_q;
   logic                  err_q;
   logic                  accept;
   logic                  req_err;

   assign accept    = (state_q == ST_IDLE) && Req_i;
   assign req_err   = access_error(mem_type_e'(MemType_i), Addr_i[1:0]);
   assign dbg_state = state_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= ST_IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (Req_i) state_d = req_err ? ST_RESP : ST_ISSUE;
         ST_ISSUE: state_d = we_q ? ST_RESP : ST_WAIT;
         ST_WAIT:  if (cnt_q == LAT_CNT) state_d = ST_RESP;
         ST_RESP:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Request fields are frozen at accept; the core may change its inputs afterwards.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         addr_q  <= '0;
         wdata_q <= '0;
         we_q    <= 1'b0;
         type_q  <= MT_WORD;
         sign_q  <= 1'b0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
         rdata_q <= '0;
      end else begin
         if (accept) begin
            addr_q  <= Addr_i;
            wdata_q <= WriteData_i;
            we_q    <= MemWrite_i;
            type_q  <= mem_type_e'(MemType_i);
            sign_q  <= MemSign_i;
            err_q   <= req_err;
            if (req_err) rdata_q <= '0;
         end
         if (state_q == ST_ISSUE) begin
            cnt_q <= CNT_W'(1);
            if (we_q) rdata_q <= '0;
         end
         if (state_q == ST_WAIT) begin
            if (cnt_q != LAT_CNT) cnt_q <= cnt_q + CNT_W'(1);
            else                  rdata_q <= ext_data;
         end
      end
   end

   load_extend u_load_extend (
      .word     (MemRdata_i),
      .offset   (addr_q[1:0]),
      .mem_type (type_q),
      .mem_sign (sign_q),
      .result   (ext_data)
   );

   always_comb begin
      case (type_q)
         MT_BYTE: store_data = {4{wdata_q[7:0]}};
         MT_HALF: store_data = {2{wdata_q[15:0]}};
         default: store_data = wdata_q;
      endcase
   end

   always_comb begin
      Ready_o    = (state_q == ST_IDLE);
      Done_o     = (state_q == ST_RESP);
      Misalign_o = (state_q == ST_RESP) && err_q;
      MemReq_o   = 1'b0;
      MemWe_o    = 1'b0;
      MemAddr_o  = '0;
      MemBe_o    = 4'b0000;
      MemWdata_o = '0;
      if (state_q == ST_ISSUE) begin
         MemReq_o   = 1'b1;
         MemWe_o    = we_q;
         MemAddr_o  = addr_q[ADDR_WIDTH-1:2];
         MemBe_o    = we_q ? byte_enables(type_q, addr_q[1:0]) : 4'b0000;
         MemWdata_o = we_q ? store_data : '0;
      end
   end

   assign ReadData_o = rdata_q;

endmodule

// File: tb/tb_datamem_ctrl.sv
// Bench for datamem_ctrl: byte-level reference memory, RAM model with
// READ_LAT pipeline, expected-response queue checked whenever Done_o fires.
module tb_datamem_ctrl;
   import core_pkg::*;

   localparam int RL = 3;

   typedef struct packed {
      logic [31:0] rdata;
      logic        mis;
      logic [31:0] done_cyc;
      logic [1:0]  reqs;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic [29:0] maddr;
      logic        we;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_ni = 1'b0;
   logic        Req_i = 1'b0;
   logic [31:0] Addr_i = '0;
   logic [31:0] WriteData_i = '0;
   logic        MemWrite_i = 1'b0;
   logic [1:0]  MemType_i = '0;
   logic        MemSign_i = 1'b0;
   logic        Ready_o, Done_o, Misalign_o, MemReq_o, MemWe_o;
   logic [31:0] ReadData_o, MemWdata_o, MemRdata_i;
   logic [29:0] MemAddr_o;
   logic [3:0]  MemBe_o;
   mem_state_e  dbg_state;

   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;
   int req_seen = 0;
   logic [3:0]  cap_be;
   logic [31:0] cap_wdata;
   logic [29:0] cap_addr;
   logic        cap_we;
   exp_t        mon_e;
   exp_t        exp_q[$];

   logic [31:0] ram  [128];
   logic [31:0] pipe [RL];
   logic [7:0]  ref_mem [512];

   always #5 clk = ~clk;

   datamem_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .READ_LAT(RL)) dut (
      .clk_i       (clk),
      .rst_ni      (rst_ni),
      .Req_i       (Req_i),
      .Addr_i      (Addr_i),
      .WriteData_i (WriteData_i),
      .MemWrite_i  (MemWrite_i),
      .MemType_i   (MemType_i),
      .MemSign_i   (MemSign_i),
      .Ready_o     (Ready_o),
      .Done_o      (Done_o),
      .ReadData_o  (ReadData_o),
      .Misalign_o  (Misalign_o),
      .MemReq_o    (MemReq_o),
      .MemWe_o     (MemWe_o),
      .MemAddr_o   (MemAddr_o),
      .MemBe_o     (MemBe_o),
      .MemWdata_o  (MemWdata_o),
      .MemRdata_i  (MemRdata_i),
      .dbg_state   (dbg_state)
   );

   always @(posedge clk) cyc <= cyc + 1;

   // RAM samples the strobe at the clock edge; read data appears RL-1 edges later.
   assign MemRdata_i = pipe[RL-1];
   always @(posedge clk) begin
      for (int i = RL - 1; i > 0; i--) pipe[i] <= pipe[i-1];
      pipe[0] <= 32'hDEADBEEF;
      if (MemReq_o) begin
         if (MemWe_o) begin
            for (int i = 0; i < 4; i++)
               if (MemBe_o[i]) ram[MemAddr_o[6:0]][8*i +: 8] <= MemWdata_o[8*i +: 8];
         end else begin
            pipe[0] <= ram[MemAddr_o[6:0]];
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic exp_t model(input logic [8:0] a, input logic [31:0] wd, input logic we,
                                  input logic [1:0] mt, input logic sg, input int acc);
      exp_t e;
      int n;
      logic [31:0] v;
      e = '0;
      n = (mt == 2'b01) ? 1 : (mt == 2'b10) ? 2 : 4;
      e.maddr = {23'b0, a[8:2]};
      if (mt == 2'b11 || (a % n) != 0) begin
         e.mis = 1'b1;
         e.done_cyc = 32'(acc);
      end else if (we) begin
         e.done_cyc = 32'(acc + 1);
         e.reqs = 2'd1;
         e.we = 1'b1;
         for (int i = 0; i < 4; i++) e.be[i] = (i >= (a % 4)) && (i < (a % 4) + n);
         e.wdata = (n == 1) ? wd[7:0] * 32'h01010101 : (n == 2) ? wd[15:0] * 32'h00010001 : wd;
         for (int i = 0; i < n; i++) ref_mem[a + i] = wd[8*i +: 8];
      end else begin
         e.done_cyc = 32'(acc + 1 + RL);
         e.reqs = 2'd1;
         v = 0;
         for (int i = 0; i < n; i++) v = v | (32'(ref_mem[a + i]) << (8 * i));
         if (n < 4 && sg == 1'b0 && v[8*n-1]) v = v - (32'd1 << (8 * n));
         e.rdata = v;
      end
      return e;
   endfunction

   always @(negedge clk) begin
      if (!rst_ni) begin
         req_seen = 0;
      end else begin
         if (MemReq_o) begin
            req_seen++;
            cap_be = MemBe_o;
            cap_wdata = MemWdata_o;
            cap_addr = MemAddr_o;
            cap_we = MemWe_o;
         end
         if (Done_o) begin
            if (exp_q.size() == 0) begin
               check("spurious_done", {31'b0, Done_o}, 32'h0);
            end else begin
               mon_e = exp_q.pop_front();
               check("misalign", {31'b0, Misalign_o}, {31'b0, mon_e.mis});
               check("read_data", ReadData_o, mon_e.rdata);
               check("done_cycle", 32'(cyc), mon_e.done_cyc);
               check("req_count", 32'(req_seen), {30'b0, mon_e.reqs});
               if (mon_e.reqs != 0) begin
                  check("mem_addr", {2'b0, cap_addr}, {2'b0, mon_e.maddr});
                  check("mem_we", {31'b0, cap_we}, {31'b0, mon_e.we});
                  check("mem_be", {28'b0, cap_be}, {28'b0, mon_e.be});
                  if (mon_e.we) check("mem_wdata", cap_wdata, mon_e.wdata);
               end
            end
            req_seen = 0;
         end
      end
   end

   task automatic access(input logic [8:0] a, input logic [31:0] wd, input logic we,
                         input logic [1:0] mt, input logic sg, input bit hold, output int acc);
      int waited;
      @(negedge clk);
      Req_i = 1'b1;
      Addr_i = {23'b0, a};
      WriteData_i = wd;
      MemWrite_i = we;
      MemType_i = mt;
      MemSign_i = sg;
      waited = 0;
      while (!Ready_o && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      if (!Ready_o) begin
         check("accept_timeout", {31'b0, Ready_o}, 32'h1);
         Req_i = 1'b0;
         acc = -1;
         return;
      end
      acc = cyc + 1;
      exp_q.push_back(model(a, wd, we, mt, sg, acc));
      @(posedge clk);
      #1;
      if (!hold) Req_i = 1'b0;
   endtask

   initial begin
      int acc1, acc2, k, n;
      logic [31:0] word;
      logic [8:0]  a;
      logic [1:0]  mt;

      for (int w = 0; w < 128; w++) begin
         word = (w == 64) ? 32'h80FF7F01 : $urandom;
         ram[w] <= word;
         for (int b = 0; b < 4; b++) ref_mem[4*w + b] = word[8*b +: 8];
      end
      for (int i = 0; i < RL; i++) pipe[i] <= '0;

      repeat (3) @(negedge clk);
      check("reset_ready", {31'b0, Ready_o}, 32'h1);
      check("reset_done", {31'b0, Done_o}, 32'h0);
      check("reset_memreq", {31'b0, MemReq_o}, 32'h0);
      check("reset_rdata", ReadData_o, 32'h0);
      check("reset_be", {28'b0, MemBe_o}, 32'h0);
      rst_ni = 1'b1;

      access(9'h101, 32'h0, 1'b0, 2'b01, 1'b0, 1'b0, acc1);
      access(9'h102, 32'h0, 1'b0, 2'b01, 1'b0, 1'b0, acc1);
      access(9'h102, 32'h0, 1'b0, 2'b01, 1'b1, 1'b0, acc1);
      access(9'h102, 32'h0, 1'b0, 2'b10, 1'b0, 1'b0, acc1);
      access(9'h102, 32'h0, 1'b0, 2'b10, 1'b1, 1'b0, acc1);
      access(9'h100, 32'h0, 1'b0, 2'b10, 1'b0, 1'b0, acc1);
      access(9'h103, 32'h000000AB, 1'b1, 2'b01, 1'b0, 1'b0, acc1);
      access(9'h100, 32'h0, 1'b0, 2'b00, 1'b0, 1'b0, acc1);
      access(9'h102, 32'h0, 1'b0, 2'b00, 1'b0, 1'b0, acc1);
      access(9'h100, 32'h0, 1'b0, 2'b11, 1'b0, 1'b0, acc1);

      access(9'h104, 32'h0, 1'b0, 2'b00, 1'b0, 1'b1, acc1);
      access(9'h108, 32'h12345678, 1'b1, 2'b00, 1'b0, 1'b0, acc2);
      check("accept_spacing", 32'(acc2 - acc1), 32'(RL + 3));

      access(9'h10C, 32'h0, 1'b0, 2'b00, 1'b0, 1'b0, acc1);
      k = 0;
      while (dbg_state != ST_WAIT && k < 20) begin
         @(negedge clk);
         k++;
      end
      check("reached_wait", {30'b0, dbg_state}, {30'b0, ST_WAIT});
      #2 rst_ni = 1'b0;
      #1;
      check("abort_ready", {31'b0, Ready_o}, 32'h1);
      check("abort_done", {31'b0, Done_o}, 32'h0);
      check("abort_memreq", {31'b0, MemReq_o}, 32'h0);
      check("abort_rdata", ReadData_o, 32'h0);
      check("abort_state", {30'b0, dbg_state}, {30'b0, ST_IDLE});
      exp_q.delete();
      @(negedge clk);
      @(negedge clk);
      #2 rst_ni = 1'b1;
      access(9'h100, 32'h0, 1'b0, 2'b00, 1'b0, 1'b0, acc1);
      access(9'h101, 32'h0, 1'b0, 2'b01, 1'b1, 1'b0, acc1);

      repeat (150) begin
         a = 9'($urandom_range(0, 511));
         mt = 2'($urandom_range(0, 3));
         n = (mt == 2'b01) ? 1 : (mt == 2'b10) ? 2 : 4;
         if ($urandom_range(0, 3) != 0) a = a & ~9'(n - 1);
         access(a, $urandom, 1'($urandom_range(0, 1)), mt, 1'($urandom_range(0, 1)), 1'b0, acc1);
      end

      k = 0;
      while (exp_q.size() != 0 && k < 100) begin
         @(negedge clk);
         k++;
      end
      if (exp_q.size() != 0) check("drain", 32'(exp_q.size()), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
